// File: rtl/fp_narrow_pipe.sv
// Narrowing IEEE-754 converter (e.g. binary64 -> binary32): rebias, RNE round, saturate/flush, quiet NaN.
// Latency: 2 cycles (S1 unpack/classify, S2 round/pack/flags), throughput 1 word/cycle.
// Backpressure: in_ready is combinational from out_ready through the two stage loads; no skid buffer.
module fp_narrow_pipe #(
   parameter int INX = 11,
   parameter int INM = 52,
   parameter int ONX = 8,
   parameter int ONM = 23
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INX+INM:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ONX+ONM:0]   out_data,
   output logic [2:0]         out_flags
);

   // Exponent arithmetic is done in INX+2 bits so the rebiased value never wraps;
   // the MSB acts as the sign of e.
   localparam int EW = INX + 2;
   // Number of mantissa bits below the guard bit that fold into sticky.
   localparam int SB = INM - ONM - 1;

   localparam logic [EW-1:0]  IXOFF  = EW'(2**(INX-1) - 1);
   localparam logic [EW-1:0]  OXOFF  = EW'(2**(ONX-1) - 1);
   localparam logic [EW-1:0]  OEMAX  = EW'(2**ONX - 1);
   localparam logic [ONM-1:0] QNAN_M = ONM'(2**(ONM-1));

   localparam logic [1:0] CL_NORM = 2'd0;
   localparam logic [1:0] CL_ZERO = 2'd1;
   localparam logic [1:0] CL_INF  = 2'd2;
   localparam logic [1:0] CL_NAN  = 2'd3;

   // ---------------- handshake ----------------
   logic w_s2_load;
   logic w_s1_load;
   logic w_in_fire;
   logic r_rdy_en;

   logic            r_s1_vld;
   logic            r_s1_sign;
   logic [1:0]      r_s1_cls;
   logic [EW-1:0]   r_s1_exp;
   logic [ONM-1:0]  r_s1_kept;
   logic            r_s1_guard;
   logic            r_s1_sticky;

   logic             r_s2_vld;
   logic [ONX+ONM:0] r_s2_dat;
   logic [2:0]       r_s2_flg;

   assign w_s2_load = !r_s2_vld | out_ready;
   assign w_s1_load = !r_s1_vld | w_s2_load;
   assign in_ready  = r_rdy_en & w_s1_load;
   assign w_in_fire = in_valid & in_ready;

   // Hold in_ready low during reset and until the first clock edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rdy_en <= 1'b0;
      else        r_rdy_en <= 1'b1;
   end

   // ---------------- S1: unpack / rebias / classify ----------------
   logic           w_in_sign;
   logic [INX-1:0] w_in_exp;
   logic [INM-1:0] w_in_mant;
   logic [EW-1:0]  w_e;
   logic [1:0]     w_cls;
   logic [ONM-1:0] w_kept;
   logic           w_guard;
   logic           w_sticky;

   assign w_in_sign = in_data[INX+INM];
   assign w_in_exp  = in_data[INX+INM-1:INM];
   assign w_in_mant = in_data[INM-1:0];
   assign w_e       = EW'(w_in_exp) - IXOFF + OXOFF;
   assign w_kept    = w_in_mant[INM-1 -: ONM];
   assign w_guard   = w_in_mant[INM-ONM-1];

   generate
      if (SB > 0) begin : g_sticky
         assign w_sticky = |w_in_mant[SB-1:0];
      end else begin : g_nosticky
         assign w_sticky = 1'b0;
      end
   endgenerate

   // Classify the incoming word; zero exponent covers both zero and denormals (flushed).
   always_comb begin
      w_cls = CL_NORM;
      if (&w_in_exp)          w_cls = (|w_in_mant) ? CL_NAN : CL_INF;
      else if (w_in_exp == '0) w_cls = CL_ZERO;
   end

   // S1 register: advances whenever S1 is empty or S2 can take its word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld    <= 1'b0;
         r_s1_sign   <= 1'b0;
         r_s1_cls    <= CL_ZERO;
         r_s1_exp    <= '0;
         r_s1_kept   <= '0;
         r_s1_guard  <= 1'b0;
         r_s1_sticky <= 1'b0;
      end else if (w_s1_load) begin
         r_s1_vld <= w_in_fire;
         if (w_in_fire) begin
            r_s1_sign   <= w_in_sign;
            r_s1_cls    <= w_cls;
            r_s1_exp    <= w_e;
            r_s1_kept   <= w_kept;
            r_s1_guard  <= w_guard;
            r_s1_sticky <= w_sticky;
         end
      end
   end

   // ---------------- S2: round / pack / flags ----------------
   logic             w_rnd_up;
   logic [ONM:0]     w_msum;
   logic [EW-1:0]    w_e_rnd;
   logic             w_uflow;
   logic             w_oflow;
   logic [ONX+ONM:0] w_res_dat;
   logic [2:0]       w_res_flg;

   assign w_rnd_up = r_s1_guard & (r_s1_sticky | r_s1_kept[0]);
   assign w_msum   = {1'b0, r_s1_kept} + {{ONM{1'b0}}, w_rnd_up};
   // A carry out of the mantissa leaves the mantissa field zero and bumps the exponent.
   assign w_e_rnd  = r_s1_exp + {{(EW-1){1'b0}}, w_msum[ONM]};
   assign w_uflow  = r_s1_exp[EW-1] | (r_s1_exp == '0);
   assign w_oflow  = !w_uflow && (w_e_rnd >= OEMAX);

   // Build the packed result and flags from the class and the rounded fields.
   always_comb begin
      w_res_dat = {r_s1_sign, {ONX{1'b0}}, {ONM{1'b0}}};
      w_res_flg = 3'b000;
      case (r_s1_cls)
         CL_NAN:  w_res_dat = {r_s1_sign, {ONX{1'b1}}, QNAN_M};
         CL_INF:  w_res_dat = {r_s1_sign, {ONX{1'b1}}, {ONM{1'b0}}};
         CL_ZERO: w_res_dat = {r_s1_sign, {ONX{1'b0}}, {ONM{1'b0}}};
         default: begin
            if (w_uflow) begin
               w_res_flg = 3'b011;
            end else if (w_oflow) begin
               w_res_dat = {r_s1_sign, {ONX{1'b1}}, {ONM{1'b0}}};
               w_res_flg = 3'b101;
            end else begin
               w_res_dat = {r_s1_sign, w_e_rnd[ONX-1:0], w_msum[ONM-1:0]};
               w_res_flg = {2'b00, r_s1_guard | r_s1_sticky};
            end
         end
      endcase
   end

   // S2 register: payload only changes on a load with a valid S1 word, so it holds under stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_vld <= 1'b0;
         r_s2_dat <= '0;
         r_s2_flg <= 3'b000;
      end else if (w_s2_load) begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_dat <= w_res_dat;
            r_s2_flg <= w_res_flg;
         end
      end
   end

   assign out_valid = r_s2_vld;
   assign out_data  = r_s2_dat;
   assign out_flags = r_s2_flg;

endmodule

// File: tb/tb_fp_narrow_pipe.sv
// Bench for fp_narrow_pipe at default parameters (binary64 -> binary32).
// Directed vector table, backpressure and mid-flight reset sequences, random soak vs arithmetic model.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_fp_narrow_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = 64'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [2:0]  out_flags;

   fp_narrow_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_out = 0;

   logic [34:0] sb_q[$];
   bit          hold_v = 1'b0;
   logic [34:0] hold_d = '0;

   typedef struct {
      logic [63:0] din;
      logic [31:0] dout;
      logic [2:0]  flg;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: value-level conversion using integer significand arithmetic.
   function automatic logic [34:0] model(input logic [63:0] d);
      logic              s;
      int                ex;
      int                e;
      logic [51:0]       m;
      longint unsigned   sig;
      longint unsigned   q;
      longint unsigned   rem;
      longint unsigned   half;
      s  = d[63];
      ex = int'(d[62:52]);
      m  = d[51:0];
      if (ex == 2047) begin
         if (m != 0) return {s, 8'hFF, 23'h400000, 3'b000};
         return {s, 8'hFF, 23'h0, 3'b000};
      end
      if (ex == 0) return {s, 31'h0, 3'b000};
      e = ex - 1023 + 127;
      if (e <= 0) return {s, 31'h0, 3'b011};
      sig  = (64'd1 << 52) | {12'h0, m};
      q    = sig >> 29;
      rem  = sig - (q << 29);
      half = 64'd1 << 28;
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0, 3'b101};
      return {s, 8'(e), q[22:0], 2'b00, (rem != 0)};
   endfunction

   function automatic logic [63:0] rand_word();
      logic [63:0] r;
      logic        s;
      logic [10:0] ex;
      r  = {$urandom, $urandom};
      s  = r[63];
      ex = r[62:52];
      case ($urandom_range(0, 5))
         0: ex = r[62:52];
         1: ex = 11'($urandom_range(894, 898));
         2: ex = 11'($urandom_range(1148, 1152));
         3: begin
            ex = 11'($urandom_range(900, 1100));
            r[28:0] = 29'h10000000;
         end
         4: begin
            ex = ($urandom_range(0, 1) == 0) ? 11'h000 : 11'h7FF;
            if ($urandom_range(0, 1) == 0) r[51:0] = 52'h0;
         end
         default: begin
            ex = 11'($urandom_range(1000, 1050));
            r[51:29] = 23'h7FFFFF;
         end
      endcase
      return {s, ex, r[51:0]};
   endfunction

   // Scoreboard, output-stability and duplicate detection, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) chk("hold_stable", {28'h0, out_valid, out_data, out_flags}, {28'h0, 1'b1, hold_d});
         hold_v = out_valid && !out_ready;
         hold_d = {out_data, out_flags};
         if (in_valid && in_ready) sb_q.push_back(model(in_data));
         if (out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_out: got %h expected no output", out_data);
            end else begin
               chk("scoreboard", {29'h0, out_data, out_flags}, {29'h0, sb_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[14];
      logic [63:0] bp[5];
      int          idx;
      int          out0;
      int          nv;
      int          cyc;

      vt[0]  = '{64'h3FF0000000000000, 32'h3F800000, 3'b000};
      vt[1]  = '{64'h400921FB54442D18, 32'h40490FDB, 3'b001};
      vt[2]  = '{64'h3FEFFFFFFFFFFFFF, 32'h3F800000, 3'b001};
      vt[3]  = '{64'h47F0000000000000, 32'h7F800000, 3'b101};
      vt[4]  = '{64'hB5B0000000000000, 32'h80000000, 3'b011};
      vt[5]  = '{64'h7FF8000000000001, 32'h7FC00000, 3'b000};
      vt[6]  = '{64'hFFF0000000000000, 32'hFF800000, 3'b000};
      vt[7]  = '{64'h0000000000000001, 32'h00000000, 3'b000};
      vt[8]  = '{64'h3FF0000010000000, 32'h3F800000, 3'b001};
      vt[9]  = '{64'h3FF0000030000000, 32'h3F800002, 3'b001};
      vt[10] = '{64'h47EFFFFFF0000000, 32'h7F800000, 3'b101};
      vt[11] = '{64'h3810000000000000, 32'h00800000, 3'b000};
      vt[12] = '{64'h3800000000000000, 32'h00000000, 3'b011};
      vt[13] = '{64'hBFF8000000000000, 32'hBFC00000, 3'b000};

      bp[0] = 64'h3FF0000000000000;
      bp[1] = 64'h4000000000000000;
      bp[2] = 64'h400921FB54442D18;
      bp[3] = 64'hC010000000000000;
      bp[4] = 64'h3FEFFFFFFFFFFFFF;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
      chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_out_data", {32'h0, out_data}, 64'h0);
      chk("rst_out_flags", {61'h0, out_flags}, 64'h0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_before_edge", {63'h0, in_ready}, 64'h0);
      @(posedge clk);
      #1;
      chk("rdy_after_edge", {63'h0, in_ready}, 64'h1);
      out_ready = 1'b1;

      // Directed vectors, one at a time, checking exact latency
      for (int i = 0; i < 14; i++) begin
         in_valid = 1'b1;
         in_data  = vt[i].din;
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(negedge clk);
         chk("lat_not_early", {63'h0, out_valid}, 64'h0);
         @(posedge clk);
         #1;
         chk("lat_valid", {63'h0, out_valid}, 64'h1);
         chk("vec_data", {32'h0, out_data}, {32'h0, vt[i].dout});
         chk("vec_flags", {61'h0, out_flags}, {61'h0, vt[i].flg});
         @(posedge clk);
         #1;
      end

      // Backpressure: five words, out_ready low for the first four cycles
      idx  = 0;
      out0 = n_out;
      for (cyc = 0; cyc < 20; cyc++) begin
         in_valid  = (idx < 5);
         in_data   = (idx < 5) ? bp[idx] : 64'h0;
         out_ready = (cyc >= 4);
         @(negedge clk);
         if (cyc == 2) begin
            chk("bp_in_ready_low", {63'h0, in_ready}, 64'h0);
            chk("bp_out_valid", {63'h0, out_valid}, 64'h1);
         end
         if (in_valid && in_ready) idx++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("bp_sent", 64'(idx), 64'd5);
      chk("bp_received", 64'(n_out - out0), 64'd5);
      chk("bp_sb_empty", 64'(sb_q.size()), 64'd0);

      // Random valid/ready soak
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = rand_word();
         out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("soak_drained", 64'(sb_q.size()), 64'd0);

      // Asynchronous reset with both stages full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h3FF0000000000000;
      @(posedge clk);
      #1 in_data = 64'h4000000000000000;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("pre_rst_valid", {63'h0, out_valid}, 64'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("arst_out_data", {32'h0, out_data}, 64'h0);
      chk("arst_in_ready", {63'h0, in_ready}, 64'h0);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      nv = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) nv++;
      end
      chk("post_rst_no_ghost", 64'(nv), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fp_narrow_pipe.md
Name: fp_narrow_pipe

Overview:
- Pipelined narrowing IEEE-754 converter. It is the reverse direction of the existing widening format conversion, e.g. double to single.
- Rebiases the exponent and rounds the mantissa to nearest-even.
- Saturates overflow to infinity, flushes underflow and input denormals to signed zero, and quiets NaNs.
- Sits between FP datapath stages behind a valid/ready stream interface and reports per-result exception flags.

Parameters:
- INX, 11, input exponent width
- INM, 52, input mantissa width (no hidden bit)
- ONX, 8, output exponent width; ONX <= INX is required
- ONM, 23, output mantissa width; ONM < INM is required

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept an input this cycle
- in_data  input  INX+INM+1  packed {sign, exp, mant}
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  ONX+ONM+1  packed {sign, exp, mant}
- out_flags  output  3  {overflow, underflow, inexact} for out_data

Behaviour:
- One clock; reset is asynchronous and active-low. While rst_n=0: both stage valids clear, out_valid=0, out_data=0, out_flags=0, in_ready=0. in_ready rises on the first clk edge after reset release.
- Reset mid-operation discards all in-flight words.
- Pipeline has two registered stages, S1 (unpack/rebias/classify) and S2 (round/pack/flags). Latency is 2 cycles from input acceptance to out_valid when there is no backpressure. Throughput is 1 word/cycle.
- Handshake:
  - Transfer occurs on a clk edge where valid and ready are both 1.
  - s2_load = !s2_valid | out_ready.
  - s1_load = !s1_valid | s2_load.
  - in_ready = s1_load; combinational from out_ready, with no skid buffer.
  - out_data and out_flags are stable while out_valid=1 and out_ready=0.
  - No word may be lost or duplicated under any valid/ready pattern.
- Offsets: IXOFF = 2^(INX-1)-1 and OXOFF = 2^(ONX-1)-1.
- S1 computes the signed exponent e = exp_in - IXOFF + OXOFF in INX+2 bits and classifies the input:
  - exp_in all ones, mant != 0: NAN
  - exp_in all ones, mant == 0: INF
  - exp_in == 0: ZERO (denormals flushed, no flags)
  - otherwise: NORM
- S1 also captures kept = mant[INM-1 -: ONM], guard = mant[INM-ONM-1], and sticky = OR of mant[INM-ONM-2:0] (0 if INM-ONM == 1).
- S2, NORM class:
  - If e <= 0: output {sign, 0, 0}, flags underflow=1, inexact=1.
  - Else apply RNE: round up iff guard & (sticky | kept[0]); inexact = guard | sticky.
  - A mantissa carry-out zeroes the mantissa and increments e.
  - If the final e >= 2^ONX-1: output {sign, all ones, 0}, flags overflow=1, inexact=1.
  - Otherwise output {sign, e[ONX-1:0], rounded mant}.
- S2, other classes:
  - NAN: output {sign, all ones, 1, zeros} (quiet NaN, payload dropped), flags 0.
  - INF: output {sign, all ones, 0}, flags 0.
  - ZERO: output {sign, 0, 0}, flags 0.
- Sign always passes through unchanged.

Test Plan:
- Reset, then in_data=0x3FF0000000000000 with out_ready=1 -> 2 cycles later out_data=0x3F800000, flags=000.
- in_data=0x400921FB54442D18 (pi) -> out_data=0x40490FDB, flags=001. in_data=0x3FEFFFFFFFFFFFFF -> mantissa carry gives out_data=0x3F800000, flags=001.
- in_data=0x47F0000000000000 -> out_data=0x7F800000, flags=101. in_data=0xB5B0000000000000 -> out_data=0x80000000, flags=011.
- in_data=0x7FF8000000000001 -> out_data=0x7FC00000, flags=000. in_data=0xFFF0000000000000 -> out_data=0xFF800000, flags=000. in_data=0x0000000000000001 -> out_data=0x00000000, flags=000.
- Stream of 5 words with out_ready held 0 for 4 cycles -> in_ready=0 once S1 and S2 are both full; out_data is held stable; all 5 results emerge in order with none lost or duplicated. A random valid/ready soak is checked against a reference model.
- rst_n pulsed low while both stages are full -> out_valid=0 immediately (asynchronous); the in-flight words never appear after reset is released.
